// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a length-prefixed little-endian program image
// over a valid/ready byte stream, writes it into instruction memory one word
// at a time, then releases the core from reset and pulses start.
module imem_boot_loader #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        start,
    output logic        done,
    output logic        err
);

    // One extra bit so a full-depth count never wraps the index.
    localparam int IW = $clog2(DEPTH_WORDS) + 1;

    localparam logic [2:0] S_HDR    = 3'd0;
    localparam logic [2:0] S_DATA   = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_LAUNCH = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    logic [2:0]    state;
    logic [1:0]    byte_cnt;
    logic [31:0]   word_buf;
    logic [IW-1:0] word_idx;
    logic [IW-1:0] n_words;

    logic          accept;
    logic          last_byte;
    logic [31:0]   full_word;

    assign rx_ready  = (state == S_HDR) || (state == S_DATA);
    assign accept    = rx_valid && rx_ready;
    assign last_byte = (byte_cnt == 2'd3);
    // Completed word as it will look once the current byte lands in lane 3.
    assign full_word = {rx_data, word_buf[23:0]};

    // Status/control outputs are pure state decodes.
    assign imem_we  = (state == S_WRITE);
    assign core_rst = !((state == S_LAUNCH) || (state == S_RUN));
    assign start    = (state == S_LAUNCH);
    assign done     = (state == S_RUN);
    assign err      = (state == S_ERR);

    // Byte assembly: counter picks the lane, wraps after every fourth byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= 2'd0;
            word_buf <= 32'd0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_buf[{byte_cnt, 3'b000} +: 8] <= rx_data;
        end
    end

    // Load sequencing: header check, per-word write, launch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_HDR;
            word_idx   <= '0;
            n_words    <= '0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'd0;
        end else begin
            case (state)
                S_HDR: begin
                    if (accept && last_byte) begin
                        if (full_word == 32'd0 || full_word > 32'(DEPTH_WORDS)) begin
                            state <= S_ERR;
                        end else begin
                            n_words <= full_word[IW-1:0];
                            state   <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept && last_byte) begin
                        // Address/data are staged here so they are stable
                        // throughout the WRITE cycle and hold afterwards.
                        imem_addr  <= BASE_ADDR + (32'(word_idx) << 2);
                        imem_wdata <= full_word;
                        state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    word_idx <= word_idx + IW'(1);
                    if (word_idx == n_words - IW'(1)) begin
                        state <= S_LAUNCH;
                    end else begin
                        state <= S_DATA;
                    end
                end
                S_LAUNCH: state <= S_RUN;
                S_RUN:    state <= S_RUN;
                S_ERR:    state <= S_ERR;
                default:  state <= S_ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed loads, bad headers,
// mid-load reset, full-depth load and randomized images with random gaps.
module tb_imem_boot_loader;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        start;
    logic        done;
    logic        err;

    imem_boot_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_rst(core_rst), .start(start),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = -10;

    // Observed activity, collected by the monitor.
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int we_cyc, start_cyc, done_cyc, start_cnt, lat_bad, rel_bad;
    bit done_seen;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: samples on the falling edge, away from state updates.
    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
            we_cyc = cyc;
            if (cyc != last_acc) lat_bad++;
        end
        if (start) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (done && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
        if ((start && core_rst) || (!core_rst && !start && !done)) rel_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wa.delete();
        wd.delete();
        start_cnt = 0; lat_bad = 0; rel_bad = 0;
        done_seen = 1'b0; we_cyc = -1; start_cyc = -1; done_cyc = -1;
    endtask

    // Entered and left on a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (rx_ready) begin
                ok = 1'b1;
                last_acc = cyc + 1;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gmin, input int gmax);
        for (int i = 0; i < 4; i++)
            send_byte(8'(w >> (8 * i)), int'($urandom_range(gmax, gmin)));
    endtask

    task automatic send_image(input logic [31:0] hdr, input logic [31:0] ws[$],
                              input int gmin, input int gmax);
        send_word(hdr, gmin, gmax);
        foreach (ws[i]) send_word(ws[i], gmin, gmax);
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        if (check) begin
            chk("rst_rx_ready", 32'(rx_ready), 32'd1);
            chk("rst_core_rst", 32'(core_rst), 32'd1);
            chk("rst_we", 32'(imem_we), 32'd0);
            chk("rst_addr", imem_addr, BASE);
            chk("rst_wdata", imem_wdata, 32'd0);
            chk("rst_start", 32'(start), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Offer a byte for several cycles and require that it is never taken.
    task automatic check_not_consumed(input string tag);
        int hits = 0;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (5) begin
            if (rx_ready) hits++;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        chk(tag, 32'(hits), 32'd0);
    endtask

    // Expected writes: word i lands at BASE + 4*i with the image's value.
    task automatic check_load(input string tag, input logic [31:0] ws[$]);
        for (int k = 0; k < 40 && !done; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_wr_count"}, 32'(wa.size()), 32'(ws.size()));
        foreach (ws[i]) begin
            if (i < wa.size()) begin
                chk({tag, "_addr"}, wa[i], BASE + 32'(4 * i));
                chk({tag, "_data"}, wd[i], ws[i]);
            end
        end
        chk({tag, "_start_cnt"}, 32'(start_cnt), 32'd1);
        chk({tag, "_start_after_write"}, 32'(start_cyc), 32'(we_cyc + 1));
        chk({tag, "_done_after_start"}, 32'(done_cyc), 32'(start_cyc + 1));
        chk({tag, "_write_latency"}, 32'(lat_bad), 32'd0);
        chk({tag, "_core_rst_timing"}, 32'(rel_bad), 32'd0);
        chk({tag, "_core_rst"}, 32'(core_rst), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        check_not_consumed({tag, "_post_done_consumed"});
    endtask

    task automatic check_err(input string tag);
        repeat (3) @(negedge clk);
        chk({tag, "_err"}, 32'(err), 32'd1);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        chk({tag, "_core_rst"}, 32'(core_rst), 32'd1);
        chk({tag, "_writes"}, 32'(wa.size()), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_start"}, 32'(start_cnt), 32'd0);
        check_not_consumed({tag, "_consumed"});
    endtask

    initial begin
        logic [31:0] two[$];
        logic [31:0] ws[$];
        logic [31:0] none[$];
        int n;

        two = '{32'h0010_0513, 32'h0020_0593};

        // Reset values, with reset raised mid-cycle.
        rst = 1'b0;
        do_reset(1'b1);

        // Two-word image, back-to-back bytes.
        clear_mon();
        send_image(32'd2, two, 0, 0);
        check_load("two_word", two);

        // Same image with three idle cycles before every byte.
        do_reset(1'b0);
        clear_mon();
        send_image(32'd2, two, 3, 3);
        check_load("stalled", two);

        // Bad headers: zero and one beyond capacity.
        do_reset(1'b0);
        clear_mon();
        send_image(32'd0, none, 0, 0);
        check_err("hdr_zero");
        do_reset(1'b0);
        clear_mon();
        send_image(32'(DEPTH + 1), none, 0, 1);
        check_err("hdr_over");

        // Abort after six data bytes (one word already written), then reload.
        do_reset(1'b0);
        send_word(32'd2, 0, 0);
        send_word(32'hDEAD_BEEF, 0, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        repeat (2) @(negedge clk);
        do_reset(1'b1);
        clear_mon();
        send_image(32'd2, two, 0, 0);
        check_load("midload", two);

        // Full depth with random contents and random gaps.
        do_reset(1'b0);
        clear_mon();
        ws.delete();
        for (int i = 0; i < DEPTH; i++) ws.push_back($urandom);
        send_image(32'(DEPTH), ws, 0, 2);
        check_load("full_depth", ws);

        // Randomized images, occasionally with an oversize header.
        for (int it = 0; it < 8; it++) begin
            do_reset(1'b0);
            clear_mon();
            ws.delete();
            if ($urandom_range(3, 0) == 0) begin
                send_image(32'(DEPTH + 1) + $urandom_range(50000, 0), none, 0, 2);
                check_err("rand_err");
            end else begin
                n = int'($urandom_range(DEPTH, 1));
                for (int i = 0; i < n; i++) ws.push_back($urandom);
                send_image(32'(n), ws, 0, 2);
                check_load("rand_load", ws);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
